// File: rtl/pulse_pkg.sv
// pulse_pkg
//   Shared definitions for the pulse qualifier: the qualifier FSM state
//   encoding, kept here so that benches and assertion binds decode the
//   debug state port the same way the RTL does.
package pulse_pkg;

  // IDLE : debounced level low, input low
  // QHI  : input seen high, counting consecutive high samples
  // HIGH : debounced level high, measuring width
  // QLO  : input seen low while high, counting consecutive low samples
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    QHI  = 2'd1,
    HIGH = 2'd2,
    QLO  = 2'd3
  } state_t;

endpackage

// File: rtl/pulse_qualifier_sync_bits.sv
// sync_bits
//   SYNC-stage single-bit synchronizer for an asynchronous level entering
//   the clk_i domain. All stages reset asynchronously to 0.
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-high reset
//   d      asynchronous input level
//   q      synchronized level (last stage)
module sync_bits #(
  parameter int SYNC = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d,
  output logic q
);

  logic [SYNC-1:0] ff;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ff <= '0;
    end else begin
      ff <= {ff[SYNC-2:0], d};
    end
  end

  assign q = ff[SYNC-1];

endmodule

// File: rtl/pulse_qualifier.sv
// pulse_qualifier
//   Recovers clean single-cycle events from an asynchronous, stretched or
//   noisy level. The input is synchronized, then each edge must be seen on
//   2^BIT consecutive samples before it is accepted. Emits a one-cycle rise
//   pulse, a one-cycle fall pulse, the debounced level, and the number of
//   cycles the debounced level was high for the last accepted pulse.
// Parameters:
//   BIT    qualification time is 2^BIT consecutive samples (0 = one sample)
//   SYNC   synchronizer depth (>= 2)
//   WBITS  width of the measured-width output
// Ports:
//   clk_i      clock
//   rst_i      asynchronous active-high reset
//   i          raw input level
//   o          one-cycle pulse on each accepted assertion of i
//   fo         one-cycle pulse on each accepted deassertion of i
//   lvl        debounced level
//   wid_o      cycles lvl was high during the last pulse, updated with fo
//   state_dbg  current FSM state (pulse_pkg::state_t encoding)
module pulse_qualifier
  import pulse_pkg::*;
#(
  parameter int BIT   = 5,
  parameter int SYNC  = 2,
  parameter int WBITS = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i,
  output logic             o,
  output logic             fo,
  output logic             lvl,
  output logic [WBITS-1:0] wid_o,
  output logic [1:0]       state_dbg
);

  localparam int unsigned    QMAX_I = (2 ** BIT) - 1;
  localparam logic [BIT:0]   QMAX   = (BIT+1)'(QMAX_I);
  localparam logic [BIT:0]   QONE   = (BIT+1)'(1);
  localparam logic [WBITS-1:0] WONE = WBITS'(1);

  logic             si;
  state_t           state;
  logic [BIT:0]     qc;
  logic [WBITS-1:0] wc;
  logic [WBITS-1:0] wc_inc;

  sync_bits #(
    .SYNC (SYNC)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d     (i),
    .q     (si)
  );

  // Width counter sticks at all-ones instead of wrapping.
  assign wc_inc = (&wc) ? wc : wc + WONE;

  assign state_dbg = state;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      qc    <= '0;
      wc    <= '0;
      o     <= 1'b0;
      fo    <= 1'b0;
      lvl   <= 1'b0;
      wid_o <= '0;
    end else begin
      o  <= 1'b0;
      fo <= 1'b0;
      unique case (state)
        IDLE: begin
          if (si) begin
            if (BIT == 0) begin
              // A single sample qualifies: accept right away.
              state <= HIGH;
              o     <= 1'b1;
              lvl   <= 1'b1;
              wc    <= WONE;
            end else begin
              state <= QHI;
              qc    <= QONE;
            end
          end
        end
        QHI: begin
          if (!si) begin
            state <= IDLE;
          end else if (qc == QMAX) begin
            state <= HIGH;
            o     <= 1'b1;
            lvl   <= 1'b1;
            wc    <= WONE;
          end else begin
            qc <= qc + QONE;
          end
        end
        HIGH: begin
          if (si) begin
            wc <= wc_inc;
          end else if (BIT == 0) begin
            state <= IDLE;
            fo    <= 1'b1;
            lvl   <= 1'b0;
            wid_o <= wc;
          end else begin
            state <= QLO;
            qc    <= QONE;
            wc    <= wc_inc;
          end
        end
        QLO: begin
          if (si) begin
            // Short dropout: still the same pulse, keep measuring.
            state <= HIGH;
            wc    <= wc_inc;
          end else if (qc == QMAX) begin
            // The release cycle itself is not counted: lvl drops here.
            state <= IDLE;
            fo    <= 1'b1;
            lvl   <= 1'b0;
            wid_o <= wc;
          end else begin
            qc <= qc + QONE;
            wc <= wc_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_qualifier.sv
// tb_pulse_qualifier
//   Three instances: A (BIT=2, WBITS=16), B (BIT=2, WBITS=4),
//   C (BIT=0, WBITS=16), all SYNC=2. A table of pulse shapes is applied,
//   expected widths are queued as each pulse is driven and matched against
//   the widths captured at every fo. Hand-written sequences cover edge
//   latency, fast toggling and asynchronous reset mid-pulse.
module tb_pulse_qualifier;
  import pulse_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic i_a, i_b, i_c;
  logic o_a, o_b, o_c, fo_a, fo_b, fo_c, lvl_a, lvl_b, lvl_c;
  logic [15:0] wid_a, wid_c;
  logic [3:0]  wid_b;
  logic [1:0]  st_a, st_b, st_c;

  pulse_qualifier #(.BIT(2), .SYNC(2), .WBITS(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .i(i_a), .o(o_a), .fo(fo_a), .lvl(lvl_a),
    .wid_o(wid_a), .state_dbg(st_a));
  pulse_qualifier #(.BIT(2), .SYNC(2), .WBITS(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .i(i_b), .o(o_b), .fo(fo_b), .lvl(lvl_b),
    .wid_o(wid_b), .state_dbg(st_b));
  pulse_qualifier #(.BIT(0), .SYNC(2), .WBITS(16)) dut_c (
    .clk_i(clk), .rst_i(rst), .i(i_c), .o(o_c), .fo(fo_c), .lvl(lvl_c),
    .wid_o(wid_c), .state_dbg(st_c));

  wire [2:0] o_v   = {o_c, o_b, o_a};
  wire [2:0] fo_v  = {fo_c, fo_b, fo_a};
  wire [2:0] lvl_v = {lvl_c, lvl_b, lvl_a};

  function automatic logic [15:0] wid_of(input int s);
    case (s)
      0:       return wid_a;
      1:       return {12'd0, wid_b};
      default: return wid_c;
    endcase
  endfunction

  function automatic logic [1:0] st_of(input int s);
    case (s)
      0:       return st_a;
      1:       return st_b;
      default: return st_c;
    endcase
  endfunction

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int o_cnt[3]  = '{0, 0, 0};
  int fo_cnt[3] = '{0, 0, 0};
  int both_cnt  = 0;
  int lvl_bad   = 0;
  logic [15:0] last_wid[3] = '{16'd0, 16'd0, 16'd0};
  logic [15:0] exp_q0[$], exp_q1[$], exp_q2[$];
  logic [15:0] got_q0[$], got_q1[$], got_q2[$];

  // Event monitor, sampling away from the active edge.
  always begin
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      if (o_v[s]) begin
        o_cnt[s] = o_cnt[s] + 1;
        if (!lvl_v[s]) lvl_bad = lvl_bad + 1;
      end
      if (fo_v[s]) begin
        fo_cnt[s] = fo_cnt[s] + 1;
        if (lvl_v[s]) lvl_bad = lvl_bad + 1;
        case (s)
          0:       got_q0.push_back(wid_of(0));
          1:       got_q1.push_back(wid_of(1));
          default: got_q2.push_back(wid_of(2));
        endcase
      end
      if (o_v[s] && fo_v[s]) both_cnt = both_cnt + 1;
    end
  end

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_i(input int s, input logic v);
    case (s)
      0:       i_a = v;
      1:       i_b = v;
      default: i_c = v;
    endcase
  endtask

  // Drive level v for n capturing edges; returns at posedge + 1.
  task automatic hold(input int s, input logic v, input int n);
    set_i(s, v);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int s, input logic [15:0] w);
    case (s)
      0:       exp_q0.push_back(w);
      1:       exp_q1.push_back(w);
      default: exp_q2.push_back(w);
    endcase
    last_wid[s] = w;
  endtask

  // Match every captured fo width against the expected queue.
  task automatic drain(input int s);
    logic [15:0] g, e;
    int ng, ne;
    forever begin
      ng = (s == 0) ? got_q0.size() : (s == 1) ? got_q1.size() : got_q2.size();
      if (ng == 0) break;
      g  = (s == 0) ? got_q0.pop_front() : (s == 1) ? got_q1.pop_front() : got_q2.pop_front();
      ne = (s == 0) ? exp_q0.size() : (s == 1) ? exp_q1.size() : exp_q2.size();
      if (ne == 0) begin
        checks++;
        errors++;
        $display("FAIL fo_unexpected dut%0d: got wid %0d expected no fo", s, g);
      end else begin
        e = (s == 0) ? exp_q0.pop_front() : (s == 1) ? exp_q1.pop_front() : exp_q2.pop_front();
        check($sformatf("wid_at_fo dut%0d", s), g, e);
      end
    end
  endtask

  typedef struct {
    int sel;
    int h1;
    int d;
    int h2;
    int lo;
    int exp_o;
    int exp_wid;
  } vec_t;

  vec_t vecs[11];

  task automatic run_vec(input vec_t v, input int idx);
    int o0, f0;
    o0 = o_cnt[v.sel];
    f0 = fo_cnt[v.sel];
    if (v.exp_o != 0) push_exp(v.sel, 16'(v.exp_wid));
    hold(v.sel, 1'b1, v.h1);
    if (v.d > 0) begin
      hold(v.sel, 1'b0, v.d);
      hold(v.sel, 1'b1, v.h2);
    end
    hold(v.sel, 1'b0, v.lo);
    drain(v.sel);
    check($sformatf("vec%0d o_count", idx), o_cnt[v.sel] - o0, v.exp_o);
    check($sformatf("vec%0d fo_count", idx), fo_cnt[v.sel] - f0, v.exp_o);
    check($sformatf("vec%0d wid_hold", idx), wid_of(v.sel), last_wid[v.sel]);
  endtask

  // Edge latency, counted in capturing edges; the input is held for
  // lat+2 edges so the expected width is lat+2.
  task automatic measure(input int s, input int lat);
    int k, o0;
    o0 = o_cnt[s];
    push_exp(s, 16'(lat + 2));
    set_i(s, 1'b1);
    k = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (o_v[s]) begin
        k = n;
        break;
      end
    end
    check($sformatf("rise_latency dut%0d", s), k, lat);
    repeat (2) @(posedge clk);
    #1;
    set_i(s, 1'b0);
    k = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (fo_v[s]) begin
        k = n;
        break;
      end
    end
    check($sformatf("fall_latency dut%0d", s), k, lat);
    repeat (4) @(posedge clk);
    #1;
    drain(s);
    check($sformatf("single_o dut%0d", s), o_cnt[s] - o0, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int o0, f0;
    // sel, h1, d, h2, lo, exp_o, exp_wid
    vecs[0]  = '{0, 20, 0, 0, 12, 1, 20};  // clean pulse
    vecs[1]  = '{0, 3, 0, 0, 12, 0, 0};    // glitch, one sample short
    vecs[2]  = '{0, 4, 0, 0, 12, 1, 4};    // shortest accepted
    vecs[3]  = '{0, 10, 3, 10, 12, 1, 23}; // dropout absorbed
    vecs[4]  = '{0, 50, 0, 0, 12, 1, 50};
    vecs[5]  = '{1, 40, 0, 0, 12, 1, 15};  // saturates
    vecs[6]  = '{1, 15, 0, 0, 12, 1, 15};  // exactly full scale
    vecs[7]  = '{1, 14, 0, 0, 12, 1, 14};
    vecs[8]  = '{2, 1, 0, 0, 8, 1, 1};     // BIT=0 single-cycle pulse
    vecs[9]  = '{2, 2, 0, 0, 8, 1, 2};
    vecs[10] = '{2, 7, 0, 0, 8, 1, 7};

    rst = 1'b1;
    i_a = 1'b0;
    i_b = 1'b0;
    i_c = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("reset o", o_a, 0);
    check("reset fo", fo_a, 0);
    check("reset lvl", lvl_a, 0);
    check("reset wid", wid_of(0), 0);
    check("reset state", st_of(0), IDLE);

    for (int n = 0; n < 11; n++) run_vec(vecs[n], n);

    measure(0, 6);
    measure(2, 3);

    // Toggling faster than the qualification time.
    o0 = o_cnt[0];
    f0 = fo_cnt[0];
    for (int n = 0; n < 10; n++) begin
      hold(0, 1'b1, 2);
      hold(0, 1'b0, 2);
    end
    for (int n = 0; n < 10; n++) begin
      hold(0, 1'b1, 3);
      hold(0, 1'b0, 3);
    end
    hold(0, 1'b0, 10);
    drain(0);
    check("toggle o_count", o_cnt[0] - o0, 0);
    check("toggle fo_count", fo_cnt[0] - f0, 0);
    check("toggle lvl", lvl_a, 0);

    // Asynchronous reset in the middle of an accepted pulse.
    hold(0, 1'b1, 10);
    check("pre_reset lvl", lvl_a, 1);
    check("pre_reset state", st_of(0), HIGH);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset o", o_a, 0);
    check("async_reset fo", fo_a, 0);
    check("async_reset lvl", lvl_a, 0);
    check("async_reset wid", wid_of(0), 0);
    check("async_reset state", st_of(0), IDLE);
    check("async_reset wid_b", wid_of(1), 0);
    set_i(0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    o0 = o_cnt[0];
    f0 = fo_cnt[0];
    hold(0, 1'b0, 15);
    drain(0);
    check("post_reset o_count", o_cnt[0] - o0, 0);
    check("post_reset fo_count", fo_cnt[0] - f0, 0);

    check("exp_q0 empty", exp_q0.size(), 0);
    check("exp_q1 empty", exp_q1.size(), 0);
    check("exp_q2 empty", exp_q2.size(), 0);
    check("o_fo_overlap", both_cnt, 0);
    check("lvl_at_edges", lvl_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
